// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit-timing helpers, parity.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver/transmitter state encoding, fixed so both sides decode the same values.
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Clock cycles per line bit; integer divide, any remainder becomes baud error.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Offset from the detected start edge to the middle of a bit.
  function automatic int calc_half_bit(input int clk_freq, input int baud);
    return calc_clks_per_bit(clk_freq, baud) / 2;
  endfunction

  // Even parity over up to 32 data bits (zero-extend narrower words).
  function automatic logic even_parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, resets to idle-high.
// Latency: 2 clk from i_async to o_sync.
// Backpressure: none.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Double-register the line; reset to 1 so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DataBits LSB-first, even parity, StopBits stops; mid-bit sampling.
// Latency: valid ~(DataBits+StopBits+1.5)*CLKS_PER_BIT+3 clk after the start edge.
// Backpressure: none; each new valid overwrites data and flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DataBits = 8,
  parameter int Baud     = 9600,
  parameter int StopBits = 2,
  parameter int ClkFreq  = 100_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rx,
  output logic [DataBits-1:0] o_data,
  output logic                o_valid,
  output logic                o_parity_err,
  output logic                o_frame_err,
  output logic                o_busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(ClkFreq, Baud);
  localparam int HALF_BIT     = calc_half_bit(ClkFreq, Baud);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_MAX      = (DataBits > StopBits) ? DataBits : StopBits;
  localparam int IDX_W        = ($clog2(IDX_MAX) > 0) ? $clog2(IDX_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DataBits - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(StopBits - 1);

  logic                w_rx_s;
  uart_state_t         r_state;
  uart_state_t         w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_bit_idx;
  logic [DataBits-1:0] r_shift;
  logic                r_parity;
  logic                r_frame;

  logic w_bit_done;
  logic w_cnt_clr;
  logic w_idx_clr;
  logic w_idx_inc;
  logic w_take_data;
  logic w_take_par;
  logic w_take_stop;
  logic w_emit;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_rx),
    .o_sync  (w_rx_s)
  );

  assign w_bit_done = (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_take_data  = 1'b0;
    w_take_par   = 1'b0;
    w_take_stop  = 1'b0;
    w_emit       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx_s) begin
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        // Re-check the line half a bit in; a high here was a glitch.
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr    = 1'b1;
          w_idx_clr    = 1'b1;
          w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_cnt_clr   = 1'b1;
          w_take_data = 1'b1;
          if (r_bit_idx == DATA_LAST) begin
            w_idx_clr    = 1'b1;
            w_next_state = ST_PARITY;
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_done) begin
          w_cnt_clr    = 1'b1;
          w_take_par   = 1'b1;
          w_idx_clr    = 1'b1;
          w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_done) begin
          w_cnt_clr   = 1'b1;
          w_take_stop = 1'b1;
          // Leave at mid-stop so a gapless next start edge is still caught.
          if (r_bit_idx == STOP_LAST) begin
            w_emit       = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Bit-period counter, bit index, shift register and captured parity/frame bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_idx_clr) begin
        r_bit_idx <= '0;
      end else if (w_idx_inc) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end

      if (w_take_data) begin
        r_shift[r_bit_idx] <= w_rx_s;
      end

      if (w_take_par) begin
        r_parity <= w_rx_s;
      end

      if (r_state == ST_START) begin
        r_frame <= 1'b0;
      end else if (w_take_stop && !w_rx_s) begin
        r_frame <= 1'b1;
      end
    end
  end

  // Output registers: updated together with a one-cycle valid on the last stop sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= w_emit;
      if (w_emit) begin
        o_data       <= r_shift;
        o_parity_err <= r_parity ^ even_parity(32'(r_shift));
        o_frame_err  <= r_frame | ~w_rx_s;
      end
    end
  end

  assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clk per bit, 8 data bits, 2 stop bits.
// Latency: frames checked after a fixed idle settle window.
// Backpressure: n/a.
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int    n_checks;
  int    n_errors;
  word_t got_q[$];
  word_t exp_q[$];
  bit    busy_seen;

  uart_rx #(
    .DataBits (8),
    .Baud     (1),
    .StopBits (2),
    .ClkFreq  (16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx         (rx),
    .o_data       (data),
    .o_valid      (valid),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every valid pulse and any busy activity on the falling edge.
  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back('{d: data, pe: parity_err, fe: frame_err});
    end
    if (busy) begin
      busy_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: what a correct receiver reports for a frame as sent.
  function automatic word_t model_word(input logic [7:0] d, input logic par,
                                       input logic s1, input logic s2);
    word_t w;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    w.d  = d;
    w.pe = (par != logic'(ones % 2));
    w.fe = !(s1 && s2);
    return w;
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    cycles(CPB);
  endtask

  // Send a full frame and queue the model's expectation; line left high.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic s1, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(s1);
    drive_bit(s2);
    rx = 1'b1;
    exp_q.push_back(model_word(d, par, s1, s2));
  endtask

  // Compare captured words against expected words, then clear both queues.
  task automatic compare_words(input string tag);
    word_t g;
    word_t e;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"}, {24'd0, g.d}, {24'd0, e.d});
      chk({tag, "_perr"}, {31'd0, g.pe}, {31'd0, e.pe});
      chk({tag, "_ferr"}, {31'd0, g.fe}, {31'd0, e.fe});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rd;
    logic       rpar;
    logic       rs1;
    logic       rs2;
    int         gap;

    n_checks  = 0;
    n_errors  = 0;
    busy_seen = 1'b0;
    rx        = 1'b1;
    rst       = 1'b1;
    cycles(4);
    chk("rst_data",  {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_perr",  {31'd0, parity_err}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cycles(20);

    // Clean frame.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    cycles(40);
    compare_words("a5");
    chk("a5_busy", {31'd0, busy}, 32'd0);

    // Wrong parity bit.
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    cycles(40);
    compare_words("par");

    // Second stop bit low, then a clean zero word.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    cycles(40);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    cycles(40);
    compare_words("stop");

    // Break: line held low for a whole frame.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    cycles(40);
    compare_words("brk");
    chk("brk_busy", {31'd0, busy}, 32'd0);

    // Short glitch low must be rejected.
    busy_seen = 1'b0;
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(40);
    chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    compare_words("glitch");

    // Back-to-back frames with no idle gap.
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    cycles(40);
    compare_words("b2b");

    // Reset in the middle of data bit 4 of 0x96.
    rd = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd[i]);
    rx = rd[4];
    cycles(CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("mid_rst_data", {24'd0, data}, 32'd0);
    chk("mid_rst_perr", {31'd0, parity_err}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    cycles(CPB * 12);
    compare_words("mid_rst");
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    cycles(40);
    compare_words("after_rst");

    // Random frames with occasional parity and stop-bit faults.
    for (int n = 0; n < 40; n++) begin
      rd   = 8'($urandom);
      rpar = ^rd;
      if ($urandom_range(0, 7) == 0) rpar = ~rpar;
      rs1 = ($urandom_range(0, 7) != 0);
      rs2 = ($urandom_range(0, 7) != 0);
      send_frame(rd, rpar, rs1, rs2);
      gap = rs2 ? int'($urandom_range(0, 20)) : int'($urandom_range(20, 30));
      if (gap > 0) cycles(gap);
    end
    cycles(40);
    compare_words("rand");
    chk("rand_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the team's UART transmitter. Frame format is start bit (0), DataBits data bits LSB first, one even-parity bit (XOR of data bits), and StopBits stop bits (1). It runs directly on the 100 MHz system clock with an internal bit-period counter; no derived clock is used. Each received word is presented with a one-cycle valid pulse and sticky-per-frame error flags.

## Interface
- DataBits, 8, data bits per frame
- Baud, 9600, line bit rate
- StopBits, 2, stop bits per frame (1 or 2)
- ClkFreq, 100_000_000, clk frequency in Hz
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, synchronous, active-high
- rx  in  1  serial line, asynchronous to clk, idles high
- data  out  DataBits  last received word, held until next valid
- valid  out  1  one-cycle pulse, data/flags updated this cycle
- parity_err  out  1  received parity != ^data, held with data
- frame_err  out  1  any stop bit sampled 0, held with data
- busy  out  1  high while state != IDLE

## Operation
- rx passes through 2-FF synchronizer (both FFs reset to 1); all logic uses synchronized rx_s.
- CLKS_PER_BIT = ClkFreq/Baud (integer divide, 10416 at defaults); HALF_BIT = CLKS_PER_BIT/2. Counter width $clog2(CLKS_PER_BIT).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: rx_s==0 -> START, counter cleared.
- START: at counter==HALF_BIT-1 sample rx_s; 0 -> DATA (counter cleared, bit index 0); 1 -> IDLE (false start, no output).
- DATA: every CLKS_PER_BIT cycles sample rx_s into shift register at bit index (LSB first); after index DataBits-1 -> PARITY.
- PARITY: sample after CLKS_PER_BIT; store bit.
- STOP: sample every CLKS_PER_BIT, StopBits samples; any 0 sets internal frame flag. After last stop sample -> IDLE in same cycle and output update.
- Output update: data <= shift register; parity_err <= parity_bit ^ (^shift); frame_err <= frame flag; valid <= 1 for exactly one cycle.
- Frames with errors still produce valid; consumer decides. Break (line held 0) yields frame_err=1, data=0, parity_err=0.
- IDLE after last stop mid-sample: next start edge accepted immediately, so back-to-back frames from a transmitter with no gap are received.

## Timing
- Reset values: data=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, synchronizer=1.
- rst mid-frame: return to IDLE next edge, no valid, partial word discarded.
- Input latency: 2 clk synchronizer delay on rx.
- valid asserts the clk after the mid-point sample of the last stop bit: ~ (1+DataBits+1+StopBits-0.5)*CLKS_PER_BIT + 3 clk after the line's falling start edge.
- Sampling points at HALF_BIT + n*CLKS_PER_BIT from detected edge; tolerance +/- ~half bit of accumulated baud error.
- Glitch low shorter than HALF_BIT clocks: rejected, busy returns low, no valid.
- No backpressure: data overwritten on next valid regardless of consumer.

## Structure
- Shared package uart_pkg: state encoding localparams (IDLE..STOP), CLKS_PER_BIT/HALF_BIT helper function of ClkFreq/Baud, parity function; also used by the transmitter.
- One sub-module: uart_rx_sync (2-FF synchronizer, reset value 1).
- Top: FSM, bit-period counter, bit index counter, shift register, output registers.

## Test plan
- Bench with ClkFreq=16, Baud=1 (CLKS_PER_BIT=16), DataBits=8, StopBits=2.
- Frame 0xA5, parity 0, stops 1,1 -> single valid pulse, data=0xA5, parity_err=0, frame_err=0, busy low after.
- Frame 0x01 with parity bit 0 -> valid, data=0x01, parity_err=1, frame_err=0.
- Frame 0x3C, second stop bit 0 -> valid, data=0x3C, frame_err=1; line then idles high and next frame 0x00 received clean.
- rx low for 3 clk then high -> busy pulses, no valid, state IDLE.
- Back-to-back 0x55 then 0xFF, no idle gap -> two valid pulses, data 0x55 then 0xFF, no errors.
- rst asserted during data bit 4 of 0x96 -> no valid, all outputs 0; following frame 0x3C received correctly.
